peak_locator: RTL and testbench

- Scans a streamed 32x32 score map in raster order (cell u = column 0..31, v = row 0..31).
- Tracks the argmax cell and publishes it as peak_u/peak_v for the video overlay stage.
- Each cell is 20x15 px of a 640x480 frame.
- Outputs change only on a video frame boundary, so the highlighted box never tears mid-frame.

---
 rtl/cv_pkg.sv | 41 ++++
 rtl/peak_locator_if.sv | 39 +++
 rtl/argmax_tracker.sv | 68 ++++++
 rtl/peak_locator.sv | 172 +++++++++++++++++
 tb/tb_peak_locator.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cv_pkg.sv
// -----------------------------------------------------------------------------
// cv_pkg - shared definitions for the peak_locator score-map block.
//
// Contents:
//   GRID_U / GRID_V   default score-map geometry (cells per row / rows per map)
//   CELL_W / CELL_H   size of one map cell in pixels on the 640x480 frame
//   SCORE_W           default score sample width
//   IDX_W             raster index width (5-bit column + 5-bit row)
//   score_t, idx_t    sample and raster-index types
//   state_e           scan controller states {IDLE, SCAN, HOLD}
//   cell_px_x/_y      pixel origin of a cell, for the overlay stage
// -----------------------------------------------------------------------------
package cv_pkg;

    localparam int GRID_U  = 32;
    localparam int GRID_V  = 32;
    localparam int CELL_W  = 20;
    localparam int CELL_H  = 15;
    localparam int SCORE_W = 16;
    localparam int IDX_W   = 10;

    typedef logic [SCORE_W-1:0] score_t;
    typedef logic [IDX_W-1:0]   idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Left pixel column of cell u (max 31*20 = 620).
    function automatic logic [9:0] cell_px_x(input logic [4:0] u);
        return 10'(u) * 10'(CELL_W);
    endfunction

    // Top pixel row of cell v (max 31*15 = 465).
    function automatic logic [8:0] cell_px_y(input logic [4:0] v);
        return 9'(v) * 9'(CELL_H);
    endfunction

endpackage

// File: rtl/peak_locator_if.sv
// -----------------------------------------------------------------------------
// peak_locator_if - score-sample stream into peak_locator.
//
// Signals:
//   s_valid  source has a sample
//   s_ready  sink accepts a sample (beat = s_valid && s_ready)
//   s_data   unsigned score, SCORE_W bits
//   s_first  sample is cell (0,0)
//   s_last   sample is the final cell of the map
//
// Modports: master = score source, slave = peak_locator.
// -----------------------------------------------------------------------------
interface peak_locator_if #(
    parameter int SCORE_W = 16
);

    logic               s_valid;
    logic               s_ready;
    logic [SCORE_W-1:0] s_data;
    logic               s_first;
    logic               s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_first,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_first,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/argmax_tracker.sv
// -----------------------------------------------------------------------------
// argmax_tracker - running maximum of a score stream and the index where it
// was first seen.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   clear_i     zero best and index (discarded accumulation)
//   load_i      start a new map: best = data_i, index = 0
//   update_i    compare data_i against best; strictly greater wins
//   data_i      score sample
//   idx_i       raster index of data_i
//   best_o      current maximum
//   best_idx_o  raster index of the current maximum
//
// Priority: clear_i > load_i > update_i.
// -----------------------------------------------------------------------------
module argmax_tracker #(
    parameter int SCORE_W = 16,
    parameter int IDX_W   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic               update_i,
    input  logic [SCORE_W-1:0] data_i,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [SCORE_W-1:0] best_o,
    output logic [IDX_W-1:0]   best_idx_o
);

    logic [SCORE_W-1:0] best_q, best_d;
    logic [IDX_W-1:0]   idx_q,  idx_d;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        best_d = best_q;
        idx_d  = idx_q;
        if (clear_i) begin
            best_d = '0;
            idx_d  = '0;
        end else if (load_i) begin
            best_d = data_i;
            idx_d  = '0;
        end else if (update_i && (data_i > best_q)) begin
            // Strict compare: on a tie the earlier raster cell is kept.
            best_d = data_i;
            idx_d  = idx_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together on the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_q <= '0;
            idx_q  <= '0;
        end else begin
            best_q <= best_d;
            idx_q  <= idx_d;
        end
    end

    assign best_o     = best_q;
    assign best_idx_o = idx_q;

endmodule

// File: rtl/peak_locator.sv
// -----------------------------------------------------------------------------
// peak_locator - finds the argmax cell of a raster-order score map and
// publishes it on a video frame boundary so the overlay box never tears.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   s            score stream (peak_locator_if.slave)
//   frame_sync   one-cycle pulse at video frame start
//   peak_u       published peak column
//   peak_v       published peak row
//   peak_score   published peak score
//   peak_update  one-cycle pulse when the published values change
//   map_err      sticky: malformed map seen (cleared only by rst)
//
// Optional feature: define PEAK_THRESH_EN to suppress publication of maps
// whose maximum is below THRESH.
// -----------------------------------------------------------------------------
module peak_locator #(
    parameter int                 SCORE_W = cv_pkg::SCORE_W,
    parameter int                 GRID_U  = cv_pkg::GRID_U,
    parameter int                 GRID_V  = cv_pkg::GRID_V,
    parameter logic [SCORE_W-1:0] THRESH  = 16'd256
) (
    input  logic                clk,
    input  logic                rst,
    peak_locator_if.slave       s,
    input  logic                frame_sync,
    output logic [4:0]          peak_u,
    output logic [4:0]          peak_v,
    output logic [SCORE_W-1:0]  peak_score,
    output logic                peak_update,
    output logic                map_err
);

    import cv_pkg::*;

    // Column bits of the raster index; the row sits above them.
    localparam int   U_W      = $clog2(GRID_U);
    localparam idx_t LAST_IDX = idx_t'(GRID_U * GRID_V - 1);

    state_e             state_q, state_d;
    idx_t               cnt_q, cnt_d;
    logic [4:0]         peak_u_q, peak_u_d;
    logic [4:0]         peak_v_q, peak_v_d;
    logic [SCORE_W-1:0] peak_score_q, peak_score_d;
    logic               peak_update_q, peak_update_d;
    logic               map_err_q, map_err_d;

    logic               beat;
    logic               trk_clear, trk_load, trk_update;
    logic [SCORE_W-1:0] best;
    idx_t               best_idx;
    logic               pass_thresh;

    assign s.s_ready = (state_q != HOLD);
    assign beat      = s.s_valid && s.s_ready;

`ifdef PEAK_THRESH_EN
    assign pass_thresh = (best >= THRESH);
`else
    assign pass_thresh = 1'b1;
`endif

    argmax_tracker #(
        .SCORE_W (SCORE_W),
        .IDX_W   (IDX_W)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (trk_clear),
        .load_i     (trk_load),
        .update_i   (trk_update),
        .data_i     (s.s_data),
        .idx_i      (cnt_q),
        .best_o     (best),
        .best_idx_o (best_idx)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        peak_u_d      = peak_u_q;
        peak_v_d      = peak_v_q;
        peak_score_d  = peak_score_q;
        peak_update_d = 1'b0;
        map_err_d     = map_err_q;
        trk_clear     = 1'b0;
        trk_load      = 1'b0;
        trk_update    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Beats before the start of a map are dropped.
                if (beat && s.s_first) begin
                    trk_load = 1'b1;
                    cnt_d    = idx_t'(1);
                    state_d  = SCAN;
                end
            end

            SCAN: begin
                if (beat) begin
                    if (s.s_first) begin
                        // New map started early: flag it and restart in place.
                        map_err_d = 1'b1;
                        trk_load  = 1'b1;
                        cnt_d     = idx_t'(1);
                    end else if (s.s_last) begin
                        if (cnt_q == LAST_IDX) begin
                            trk_update = 1'b1;
                            state_d    = HOLD;
                        end else begin
                            map_err_d = 1'b1;
                            trk_clear = 1'b1;
                            state_d   = IDLE;
                        end
                    end else if (cnt_q == LAST_IDX) begin
                        // Map would exceed GRID_U*GRID_V cells without s_last.
                        map_err_d = 1'b1;
                        trk_clear = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        trk_update = 1'b1;
                        cnt_d      = cnt_q + idx_t'(1);
                    end
                end
            end

            HOLD: begin
                if (frame_sync) begin
                    state_d = IDLE;
                    if (pass_thresh) begin
                        peak_u_d      = 5'(best_idx & idx_t'(GRID_U - 1));
                        peak_v_d      = 5'(best_idx >> U_W);
                        peak_score_d  = best;
                        peak_update_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            peak_u_q      <= '0;
            peak_v_q      <= '0;
            peak_score_q  <= '0;
            peak_update_q <= 1'b0;
            map_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            peak_u_q      <= peak_u_d;
            peak_v_q      <= peak_v_d;
            peak_score_q  <= peak_score_d;
            peak_update_q <= peak_update_d;
            map_err_q     <= map_err_d;
        end
    end

    assign peak_u      = peak_u_q;
    assign peak_v      = peak_v_q;
    assign peak_score  = peak_score_q;
    assign peak_update = peak_update_q;
    assign map_err     = map_err_q;

endmodule

// File: tb/tb_peak_locator.sv
// -----------------------------------------------------------------------------
// tb_peak_locator - self-checking bench for peak_locator.
//
// Maps are held as plain arrays; the expected peak is the first raster cell
// holding the array maximum. A small behavioural model tracks whether a
// completed map is waiting for frame_sync, the published values and the
// sticky error flag. Honours PEAK_THRESH_EN when the same macro is defined.
// -----------------------------------------------------------------------------
module tb_peak_locator;

    import cv_pkg::*;

    localparam int          N   = GRID_U * GRID_V;
    localparam int unsigned THR = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_sync;
    logic [4:0]  peak_u;
    logic [4:0]  peak_v;
    logic [15:0] peak_score;
    logic        peak_update;
    logic        map_err;

    peak_locator_if #(.SCORE_W(16)) s_if ();

    peak_locator #(
        .SCORE_W (16),
        .GRID_U  (32),
        .GRID_V  (32),
        .THRESH  (16'd256)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s           (s_if),
        .frame_sync  (frame_sync),
        .peak_u      (peak_u),
        .peak_v      (peak_v),
        .peak_score  (peak_score),
        .peak_update (peak_update),
        .map_err     (map_err)
    );

    always #5 clk = ~clk;

    // Reference state
    int unsigned map_a [N];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          pulses   = 0;
    int unsigned exp_u, exp_v, exp_score;
    bit          exp_err;
    bit          hold;          // completed map waiting for frame_sync
    int unsigned pend_u, pend_v, pend_score;
    bit          pend_pub;
`ifdef PEAK_THRESH_EN
    bit          thresh_on = 1'b1;
`else
    bit          thresh_on = 1'b0;
`endif

    always @(negedge clk) if (peak_update === 1'b1) pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " peak_u"},     32'(peak_u),     exp_u);
        check({tag, " peak_v"},     32'(peak_v),     exp_v);
        check({tag, " peak_score"}, 32'(peak_score), exp_score);
        check({tag, " map_err"},    32'(map_err),    32'(exp_err));
        check({tag, " s_ready"},    32'(s_if.s_ready), 32'(!hold));
    endtask

    // One clock of stimulus; returns 1 time unit after the sampling edge.
    task automatic drive(input logic v, input logic [15:0] d, input logic f,
                         input logic l, input logic fs);
        s_if.s_valid = v;
        s_if.s_data  = d;
        s_if.s_first = f;
        s_if.s_last  = l;
        frame_sync   = fs;
        @(posedge clk);
        #1;
        s_if.s_valid = 1'b0;
        s_if.s_first = 1'b0;
        s_if.s_last  = 1'b0;
        frame_sync   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        exp_u = 0; exp_v = 0; exp_score = 0; exp_err = 1'b0; hold = 1'b0;
    endtask

    task automatic fill_random(input int unsigned max_v);
        for (int i = 0; i < N; i++) map_a[i] = $urandom_range(0, max_v);
    endtask

    // Streams cells 0..n-1 with random valid bubbles. Bubbles carry random
    // first/last/frame_sync, all of which must be ignored.
    task automatic send_cells(input int n, input bit with_last, input bit fs_on_last);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 7) == 0)
                drive(1'b0, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            drive(1'b1, 16'(map_a[i]), i == 0, with_last && (i == n - 1),
                  fs_on_last && (i == n - 1));
        end
    endtask

    // Model: first occurrence of the maximum in raster order.
    task automatic model_complete();
        int best_i = 0;
        for (int i = 1; i < N; i++) if (map_a[i] > map_a[best_i]) best_i = i;
        pend_u     = best_i % GRID_U;
        pend_v     = best_i / GRID_U;
        pend_score = map_a[best_i];
        pend_pub   = !thresh_on || (map_a[best_i] >= THR);
        hold       = 1'b1;
    endtask

    // Pulses frame_sync and checks the result one cycle later.
    task automatic frame_pulse(input string tag);
        int p0  = pulses;
        bit pub = hold && pend_pub;
        drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
        if (pub) begin
            exp_u = pend_u; exp_v = pend_v; exp_score = pend_score;
        end
        hold = 1'b0;
        check({tag, " peak_update"}, 32'(peak_update), 32'(pub));
        check_outputs(tag);
        idle(1);
        check({tag, " pulse count"}, 32'(pulses - p0), 32'(pub));
    endtask

    initial begin
        bit ready_low;
        int p0;
        s_if.s_valid = 1'b0; s_if.s_data = '0; s_if.s_first = 1'b0; s_if.s_last = 1'b0;
        frame_sync = 1'b0;

        // Reset state
        do_reset();
        check("reset peak_update", 32'(peak_update), 32'd0);
        check_outputs("reset");

        // 1: single hot cell at index 37 -> (5,1)
        for (int i = 0; i < N; i++) map_a[i] = 0;
        map_a[37] = 500;
        send_cells(N, 1'b1, 1'b0);
        model_complete();
        check_outputs("t1 hold");
        frame_pulse("t1");
        check("t1 const u", 32'(peak_u), 32'd5);
        check("t1 const v", 32'(peak_v), 32'd1);
        check("t1 const score", 32'(peak_score), 32'd500);

        // 2: tie between cells 10 and 900 keeps the earlier one
        fill_random(999);
        map_a[10] = 1000; map_a[900] = 1000;
        send_cells(N, 1'b1, 1'b0);
        model_complete();
        frame_pulse("t2");
        check("t2 const u", 32'(peak_u), 32'd10);
        check("t2 const v", 32'(peak_v), 32'd0);

        // Random full-range maps; frame_sync in IDLE must do nothing
        for (int k = 0; k < 3; k++) begin
            fill_random(32'hFFFF);
            frame_pulse("idle fs");
            send_cells(N, 1'b1, 1'b0);
            model_complete();
            frame_pulse("rand");
        end

        // 3: completed map held 50 cycles; offered beats refused
        fill_random(5000);
        send_cells(N, 1'b1, 1'b0);
        model_complete();
        p0 = pulses;
        ready_low = 1'b1;
        for (int i = 0; i < 50; i++) begin
            drive(1'b1, 16'hFFFF, 1'($urandom), 1'($urandom), 1'b0);
            if (s_if.s_ready !== 1'b0) ready_low = 1'b0;
        end
        check("t3 ready low in hold", 32'(ready_low), 32'd1);
        check("t3 no pulse in hold", 32'(pulses - p0), 32'd0);
        check_outputs("t3 held");
        frame_pulse("t3");

        // frame_sync coinciding with the final beat waits for the next one
        fill_random(32'hFFFF);
        p0 = pulses;
        send_cells(N, 1'b1, 1'b1);
        model_complete();
        idle(3);
        check("coincide no pulse", 32'(pulses - p0), 32'd0);
        check_outputs("coincide held");
        frame_pulse("coincide");

        // 4: s_last at beat 600 -> error, no publication
        fill_random(32'hFFFF);
        send_cells(601, 1'b1, 1'b0);
        exp_err = 1'b1;
        check_outputs("t4 err");
        frame_pulse("t4 no pub");
        fill_random(32'hFFFF);
        send_cells(N, 1'b1, 1'b0);
        model_complete();
        frame_pulse("t4 recover");

        // s_first inside a scan restarts on the new map
        fill_random(32'hFFFF);
        map_a[5] = 32'hFFFF;
        send_cells(100, 1'b0, 1'b0);
        fill_random(32'hFFFF);
        send_cells(N, 1'b1, 1'b0);
        model_complete();
        frame_pulse("restart");

        // 5: reset at beat 400, then un-started beats are dropped
        fill_random(32'hFFFF);
        send_cells(400, 1'b0, 1'b0);
        do_reset();
        check_outputs("t5 reset");
        for (int i = 0; i < 60; i++)
            drive(1'b1, 16'($urandom), 1'b0, 1'($urandom), 1'b0);
        check_outputs("t5 dropped");
        frame_pulse("t5 no pub");

        // Overflow: N cells without s_last
        fill_random(32'hFFFF);
        send_cells(N, 1'b0, 1'b0);
        exp_err = 1'b1;
        check_outputs("overflow");
        frame_pulse("overflow no pub");

        // 6: low-max map (suppressed only with threshold), then 300 at (31,31)
        fill_random(99);
        map_a[$urandom_range(0, N - 1)] = 100;
        send_cells(N, 1'b1, 1'b0);
        model_complete();
        frame_pulse("t6 low");
        fill_random(299);
        map_a[N - 1] = 300;
        send_cells(N, 1'b1, 1'b0);
        model_complete();
        frame_pulse("t6 high");
        check("t6 const u", 32'(peak_u), 32'd31);
        check("t6 const v", 32'(peak_v), 32'd31);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
